dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Two-requester arbiter that shares one port of the 1,024 x 16-bit dual-port block RAM. Requester 0 is the CPU load/store unit and requester 1 is the VGA/IO fetch engine. The block grants one access per cycle using round-robin with an optional lock for atomic multi-cycle sequences. It drives the RAM port's write-enable/address/data signals and returns read data tagged to the requester that issued the read.

## Interface
- AW, 10, address width (word address into the RAM).
- DW, 16, data width.
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request; held until granted.
- we0, we1  in  1  1 = write, 0 = read.
- lock0, lock1  in  1  keep ownership after this access.
- addr0, addr1  in  AW  word address.
- wdata0, wdata1  in  DW  write data.
- gnt0, gnt1  out  1  combinational; the access is taken at the next clk edge.
- rvalid0, rvalid1  out  1  registered; rdata holds read data for that requester.
- rdata  out  DW  read data, passthrough of ram_q.
- ram_we  out  1  RAM port write enable (RAM en; 1 = write, 0 = read).
- ram_addr  out  AW  RAM port address.
- ram_wdata  out  DW  RAM port write data.
- ram_q  in  DW  RAM port registered output; valid one cycle after the address is issued.

## Operation
- Ownership state machine, register `own`:
  - FREE: arbitrate by round-robin.
  - OWN0: only requester 0 may be granted.
  - OWN1: only requester 1 may be granted.
- Register `last` holds the last granted requester.
- Grant rules in FREE:
  - Only one request active: that requester is granted.
  - Both requests active: the requester that is not `last` is granted.
- OWNx:
  - Only reqx can be granted.
  - The other requester waits, even if reqx is low.
- Port mux:
  - When a grant is active, the granted requester's we/addr/wdata drive the ram_* outputs.
  - With no grant, ram_we=0, ram_addr holds its last value, and ram_wdata=0. An idle read is harmless.
- State transitions at the clock edge of a granted access by x:
  - lockx=1: own becomes OWNx.
  - lockx=0: own becomes FREE.
  - `last` becomes x.
- Also, in OWNx, any cycle with reqx=0 and lockx=0 returns own to FREE. This is the escape for an abandoned lock.
- Reads: a granted read by x sets internal pend_x for one cycle, so rvalidx=1 in the next cycle and rdata=ram_q.
- Writes: gnt is the completion signal and no rvalid follows. Read-after-write to the same address in consecutive grants returns the new data.
- gnt0 and gnt1 are never asserted together.
- rvalid0 and rvalid1 are never asserted together.

## Timing
- Reset values: own=FREE, last=1 (so requester 0 wins the first tie), rvalid0=rvalid1=0, ram_addr=0.
- gnt outputs are combinational from req/lock/own/last. The ram_we, ram_wdata and rdata outputs are also combinational. ram_addr holds its last value when there is no grant.
- Throughput: one access per cycle, with back-to-back grants allowed.
- Read latency: address issued in cycle N, rvalid and data in cycle N+1.
- Requesters may change addr/we/wdata in the cycle after gnt.
- Reset asserted mid-operation:
  - Clears rvalid immediately and discards any in-flight read.
  - Clears lock ownership immediately.
  - The RAM contents are not touched.
- Simultaneous requests from both requesters, FREE, last=0: requester 1 is granted and requester 0 holds req.
- Locked requester issues a final access with lock=0: own returns to FREE at that edge. The other requester can be granted in the following cycle.

## Test plan
- Reset, then req0 read addr 0x005 alone: gnt0=1 in the same cycle, rvalid0=1 next cycle with rdata equal to the preloaded word. rvalid1 stays 0.
- Both requesters hold continuous reads (req0: 0x010, req1: 0x020) for 6 cycles: grants alternate 0,1,0,1,0,1. The rvalids alternate one cycle later with the correct data.
- req0 writes 0xBEEF to 0x3FF, then reads 0x3FF in the next cycle: gnt0 on both cycles, no rvalid after the write, rvalid0 with rdata=0xBEEF after the read.
- req1 holds lock1=1 for 3 accesses while req0 is held high: gnt0 stays 0 for all 3 cycles. On the 4th access, lock1=0 and own goes FREE, and gnt0=1 on the next cycle.
- rst_n pulsed low the cycle after a granted read by requester 1: rvalid1=0 and own=FREE. After reset, req0 and req1 are both high and requester 0 is granted first.
- Stale lock: req0 granted with lock0=1, then req0=lock0=0 for one cycle: own returns to FREE and a pending req1 is granted the cycle after.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin / lockable arbiter sharing one DPRAM port between two requesters
//
// Shares a single block-RAM port between requester 0 (CPU load/store) and
// requester 1 (VGA/IO fetch). One access is granted per cycle. With both
// requesting and no owner, the requester that was not granted last wins.
// A granted access with lockx=1 reserves the port for requester x until it
// issues an access with lockx=0, or until it drops both req and lock.
//
// Ports
//   clk, rst_n             clock shared with the RAM; asynchronous active-low reset
//   reqx, wex, lockx       request, write (1) / read (0), keep ownership after this access
//   addrx, wdatax          word address and write data of requester x
//   gntx                   combinational grant; the access is taken at the next clk edge
//   rvalidx                registered; rdata carries read data for requester x
//   rdata                  passthrough of ram_q
//   ram_we/addr/wdata      RAM port controls; ram_addr holds its value while idle
//   ram_q                  RAM registered read data, valid one cycle after the address
module dpram_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {
    OWN_FREE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } own_e;

  own_e          own_q, own_d;
  logic          last_q, last_d;
  logic          pend0_q, pend0_d;
  logic          pend1_q, pend1_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;

  // Grant decode. In FREE a tie goes to whoever was not granted last
  // (last_q=1 means requester 1 went last, so requester 0 wins).
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (own_q)
      OWN_0: gnt0 = req0;
      OWN_1: gnt1 = req1;
      default: begin
        if (req0 && req1) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

  // Ownership / round-robin state. A granted access decides ownership from
  // its own lock bit; an owner that drops both req and lock releases the
  // port so an abandoned lock cannot starve the other requester.
  always_comb begin
    own_d  = own_q;
    last_d = last_q;
    if (gnt0) begin
      own_d  = lock0 ? OWN_0 : OWN_FREE;
      last_d = 1'b0;
    end else if (gnt1) begin
      own_d  = lock1 ? OWN_1 : OWN_FREE;
      last_d = 1'b1;
    end else if ((own_q == OWN_0) && !req0 && !lock0) begin
      own_d = OWN_FREE;
    end else if ((own_q == OWN_1) && !req1 && !lock1) begin
      own_d = OWN_FREE;
    end
  end

  // RAM port mux. The RAM samples ram_addr at the grant edge, so the
  // granted address is passed straight through; while idle the previous
  // address is held to avoid needless toggling on the RAM address bus.
  always_comb begin
    ram_we     = 1'b0;
    ram_wdata  = '0;
    ram_addr   = ram_addr_q;
    if (gnt0) begin
      ram_we    = we0;
      ram_wdata = wdata0;
      ram_addr  = addr0;
    end else if (gnt1) begin
      ram_we    = we1;
      ram_wdata = wdata1;
      ram_addr  = addr1;
    end
    ram_addr_d = ram_addr;
  end

  // A granted read returns on ram_q one cycle later; tag it to its requester.
  always_comb begin
    pend0_d = gnt0 && !we0;
    pend1_d = gnt1 && !we1;
  end

  assign rvalid0 = pend0_q;
  assign rvalid1 = pend1_q;
  assign rdata   = ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q      <= OWN_FREE;
      last_q     <= 1'b1;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      own_q      <= own_d;
      last_q     <= last_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      ram_addr_q <= ram_addr_d;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - self-checking bench for dpram_port_arbiter with RAM model and reference model
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [9:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_q;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_own;        // -1 free, else owning requester
  int          m_last;       // last granted requester
  int          m_pend;       // -1 none, else requester expecting read data this cycle
  logic [15:0] m_pend_data;
  logic [9:0]  m_addr_hold;
  logic [15:0] exp_mem [0:1023];

  logic g0_seen, g1_seen;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.AW(10), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_q(ram_q)
  );

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 40503) ^ 32'h5A3C);
  endfunction

  // RAM: 1024 x 16, registered read output, preloaded on its first clock
  logic [15:0] mem [0:1023];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own       = -1;
    m_last      = 1;
    m_pend      = -1;
    m_addr_hold = 10'd0;
  endtask

  // One clock cycle: called at posedge+1 after inputs are set. Checks
  // mid-cycle, then advances the model across the edge.
  task automatic cyc(input string tag);
    logic        r [2];
    logic        w [2];
    logic        l [2];
    logic [9:0]  a [2];
    logic [15:0] d [2];
    int          win;
    r[0] = req0; w[0] = we0; l[0] = lock0; a[0] = addr0; d[0] = wdata0;
    r[1] = req1; w[1] = we1; l[1] = lock1; a[1] = addr1; d[1] = wdata1;
    #4;
    win = -1;
    if (m_own >= 0) begin
      if (r[m_own]) win = m_own;
    end else if (r[0] && r[1]) begin
      win = 1 - m_last;
    end else if (r[0]) begin
      win = 0;
    end else if (r[1]) begin
      win = 1;
    end
    chk({tag, "_gnt0"}, 32'(gnt0), 32'(win == 0));
    chk({tag, "_gnt1"}, 32'(gnt1), 32'(win == 1));
    chk({tag, "_gnt_excl"}, 32'(gnt0 & gnt1), 32'd0);
    chk({tag, "_rv_excl"}, 32'(rvalid0 & rvalid1), 32'd0);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'(m_pend == 0));
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'(m_pend == 1));
    if (m_pend >= 0) chk({tag, "_rdata"}, 32'(rdata), 32'(m_pend_data));
    if (win >= 0) begin
      chk({tag, "_ram_we"}, 32'(ram_we), 32'(w[win]));
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(a[win]));
      chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'(d[win]));
    end else begin
      chk({tag, "_idle_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_idle_addr"}, 32'(ram_addr), 32'(m_addr_hold));
      chk({tag, "_idle_wdata"}, 32'(ram_wdata), 32'd0);
    end
    g0_seen = gnt0;
    g1_seen = gnt1;
    @(posedge clk);
    if (win >= 0) begin
      if (w[win]) begin
        exp_mem[a[win]] = d[win];
        m_pend = -1;
      end else begin
        m_pend      = win;
        m_pend_data = exp_mem[a[win]];
      end
      m_own       = l[win] ? win : -1;
      m_last      = win;
      m_addr_hold = a[win];
    end else begin
      m_pend = -1;
      if (m_own >= 0 && !r[m_own] && !l[m_own]) m_own = -1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1;
    cyc("idle");

    // single read by requester 0
    req0 = 1; addr0 = 10'h005;
    cyc("t1");
    chk("t1_gnt0_same_cycle", 32'(g0_seen), 32'd1);
    chk("t1_rvalid0", 32'(rvalid0), 32'd1);
    chk("t1_rdata", 32'(rdata), 32'(init_word(5)));
    chk("t1_rvalid1", 32'(rvalid1), 32'd0);
    idle_inputs();
    cyc("t1_idle");

    // make requester 1 the last winner, then alternate continuous reads
    req1 = 1; addr1 = 10'h020;
    cyc("t2_pre");
    req0 = 1; addr0 = 10'h010;
    for (int i = 0; i < 6; i++) begin
      cyc("t2");
      chk("t2_alt_gnt0", 32'(g0_seen), 32'(i % 2 == 0));
      chk("t2_alt_rvalid0", 32'(rvalid0), 32'(i % 2 == 0));
      chk("t2_alt_rdata", 32'(rdata), (i % 2 == 0) ? 32'(init_word(16)) : 32'(init_word(32)));
    end
    idle_inputs();
    cyc("t2_idle");

    // write then read-back of the top word
    req0 = 1; we0 = 1; addr0 = 10'h3FF; wdata0 = 16'hBEEF;
    cyc("t3w");
    chk("t3w_gnt0", 32'(g0_seen), 32'd1);
    chk("t3w_no_rvalid", 32'(rvalid0), 32'd0);
    we0 = 0; wdata0 = '0;
    cyc("t3r");
    chk("t3r_gnt0", 32'(g0_seen), 32'd1);
    chk("t3r_rvalid0", 32'(rvalid0), 32'd1);
    chk("t3r_rdata", 32'(rdata), 32'hBEEF);
    idle_inputs();

    // requester 1 holds the lock for 3 accesses while requester 0 waits
    req0 = 1; addr0 = 10'h010;
    req1 = 1; lock1 = 1; addr1 = 10'h020;
    for (int i = 0; i < 3; i++) begin
      cyc("t4_lock");
      chk("t4_lock_gnt0", 32'(g0_seen), 32'd0);
      chk("t4_lock_gnt1", 32'(g1_seen), 32'd1);
    end
    lock1 = 0;
    cyc("t4_final");
    chk("t4_final_gnt1", 32'(g1_seen), 32'd1);
    req1 = 0;
    cyc("t4_after");
    chk("t4_after_gnt0", 32'(g0_seen), 32'd1);
    idle_inputs();
    cyc("t4_idle");

    // reset right after a granted read by requester 1
    req1 = 1; addr1 = 10'h123;
    cyc("t5a");
    chk("t5_rvalid1_pre", 32'(rvalid1), 32'd1);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid1_rst", 32'(rvalid1), 32'd0);
    chk("t5_rvalid0_rst", 32'(rvalid0), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0 = 1; addr0 = 10'h001; req1 = 1; addr1 = 10'h002;
    cyc("t5b");
    chk("t5b_gnt0_first", 32'(g0_seen), 32'd1);
    idle_inputs();

    // stale lock released by dropping req and lock
    req0 = 1; lock0 = 1; addr0 = 10'h030;
    cyc("t6a");
    chk("t6a_gnt0", 32'(g0_seen), 32'd1);
    req0 = 0; lock0 = 0; req1 = 1; addr1 = 10'h031;
    cyc("t6b");
    chk("t6b_gnt1_blocked", 32'(g1_seen), 32'd0);
    cyc("t6c");
    chk("t6c_gnt1", 32'(g1_seen), 32'd1);
    idle_inputs();
    cyc("t6_idle");

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      req0   = ($urandom_range(0, 3) != 0);
      we0    = ($urandom_range(0, 2) == 0);
      lock0  = ($urandom_range(0, 4) == 0);
      addr0  = 10'($urandom_range(0, 15)) | 10'h3F0;
      wdata0 = 16'($urandom);
      req1   = ($urandom_range(0, 3) != 0);
      we1    = ($urandom_range(0, 2) == 0);
      lock1  = ($urandom_range(0, 4) == 0);
      addr1  = 10'($urandom_range(0, 15)) | 10'h3F0;
      wdata1 = 16'($urandom);
      cyc("rnd");
    end
    idle_inputs();
    cyc("end_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
